serializer: RTL and testbench
=============================

# serializer

Parallel-to-serial converter for the FIR filter's output path: it accepts LENGTH-bit sample words through a valid/ready handshake and shifts them out one bit per enabled clock, LSB first. Each word is followed by a one-cycle frame strobe on the enabled cycle after its last bit. This bit order and strobe placement are exactly what the `deserializer` on the receive side expects, so serializer → deserializer on a shared `i_en` reproduces every word unchanged. A one-word holding register lets words stream back-to-back with no idle bit between them.

## Interface
- `LENGTH`, 24: word width in bits; must be ≥ 2.
- `i_clk`  in  1  rising-edge clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_en`  in  1  bit-rate clock enable; shifting, loading and the strobe advance only on edges where `i_en`=1.
- `iv_din`  in  LENGTH  parallel word to send.
- `i_din_valid`  in  1  `iv_din` is valid.
- `o_din_ready`  out  1  holding register empty; a word is accepted on any edge with `i_din_valid` & `o_din_ready`, independent of `i_en`.
- `o_dout`  out  1  serial data, registered.
- `o_dout_valid`  out  1  frame strobe, registered; high for exactly one enabled cycle after the last bit of each word.
- `o_busy`  out  1  a word is in the shift register or the holding register.

## Operation
- Storage: holding register `hold` plus `hold_full` flag; shift register; bit counter `cnt` (0..LENGTH-1, width $clog2(LENGTH)); `active` flag.
- `o_din_ready` = ~`hold_full`. An accepted word sets `hold_full` on that edge.
- Enabled edge, `active`=0:
  - If `hold_full`: load `hold` into the shift register, clear `hold_full`, set `active`, set `o_dout` = bit 0, set `cnt` = 0.
  - Otherwise: `o_dout` = 0.
- Enabled edge, `active`=1, `cnt` < LENGTH-1: `o_dout` = next bit, `cnt` += 1.
- Enabled edge, `active`=1, `cnt` = LENGTH-1 (last bit was on the line): set `o_dout_valid` = 1.
  - If `hold_full`: load it on this same edge; `o_dout` = bit 0 of the new word, `cnt` = 0, `active` stays 1 (back-to-back, no gap).
  - Otherwise: `active` = 0, `o_dout` = 0.
- `o_dout_valid` is cleared on the next enabled edge. It is never high for two consecutive enabled cycles.
- Accept and load on the same edge: the load consumes the old `hold` and the accept refills it, so `hold_full` stays 1. An accept is never dropped.
- `i_en`=0: all outputs and state hold, except that acceptance into an empty `hold` still occurs.
- `o_busy` = `active` | `hold_full`.

## Timing
- Reset (async assert, released synchronously to `i_clk` by the system): `o_dout`=0, `o_dout_valid`=0, `o_din_ready`=1, `o_busy`=0, `cnt`=0, `active`=0, `hold_full`=0.
- Reset mid-word: the word in flight and the held word are discarded; no strobe is emitted.
- Latency: a word accepted at edge t drives bit 0 at the first enabled edge after t. The accept edge itself never loads.
- Word period: exactly LENGTH enabled cycles back-to-back. The strobe overlaps bit 0 of the next word.
- Isolated word: LENGTH bit cycles, then one strobe cycle with `o_dout`=0.
- Combined with a `deserializer` on the same clock and `i_en`: its `ov_dout` equals the sent word one enabled edge after this block's strobe.
- `o_din_ready` drops the edge after an accept. It rises on the enabled edge that loads `hold`, provided no simultaneous accept.

## Test plan
- Reset, then `i_en`=1 constant; send 24'hA5F00F with no other traffic. Required: `o_dout` = 1,1,1,1,0,0,0,0,… (LSB first) over 24 cycles, then `o_dout_valid`=1 for one cycle with `o_dout`=0, then `o_busy`=0.
- Stream 24'h000001, 24'h800000, 24'hFFFFFF with `i_din_valid` held high. Required: 72 contiguous bit cycles with no gap, exactly 3 strobes, each coinciding with bit 0 of the following word (or idle after the last); `o_din_ready` never lets a word drop.
- Loop-back into a `deserializer` with `i_en` toggling 1-in-3; send 100 random words. Required: the received words equal the sent words in order; `o_dout`/`o_dout_valid` change only on enabled edges.
- Hold `i_din_valid` high while `hold_full`=1. Required: `o_din_ready`=0 and `iv_din` changes are ignored until the load edge.
- Assert `i_rst` at bit 10 of a word with a second word held. Required: all outputs reach their reset values immediately; no strobe; the next accepted word 24'h123456 serializes correctly.
- LENGTH=2 build: send 2'b10, 2'b01 back-to-back. Required: `o_dout` = 0,1,1,0, with strobes at bit cycles 3 and 5.

Source files
------------

// File: rtl/serializer_if.sv
// Word-in / bit-out handshake bundle for the serializer.
`timescale 1ns/1ps
interface serializer_if #(
  parameter int LENGTH = 24
) ();
  logic [LENGTH-1:0] iv_din;
  logic              i_din_valid;
  logic              o_din_ready;
  logic              o_dout;
  logic              o_dout_valid;
  logic              o_busy;

  modport master (
    output iv_din,
    output i_din_valid,
    input  o_din_ready,
    input  o_dout,
    input  o_dout_valid,
    input  o_busy
  );

  modport slave (
    input  iv_din,
    input  i_din_valid,
    output o_din_ready,
    output o_dout,
    output o_dout_valid,
    output o_busy
  );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter, LSB first, with a one-word holding register
// and a frame strobe on the enabled cycle after each word's last bit.
`timescale 1ns/1ps
module serializer #(
  parameter int LENGTH = 24
) (
  input logic         i_clk,
  input logic         i_rst,
  input logic         i_en,
  serializer_if.slave bus
);
  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  logic [LENGTH-1:0] r_hold;
  logic              r_hold_full;
  logic [LENGTH-2:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_active;
  logic              r_dout;
  logic              r_dout_valid;

  logic w_accept;
  logic w_last;
  logic w_load;

  assign w_accept = bus.i_din_valid & ~r_hold_full;
  assign w_last   = r_active & (r_cnt == LAST);
  // Load on an idle enabled edge or straight over the last bit.
  assign w_load   = i_en & r_hold_full & (~r_active | w_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_active     <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_accept)
        r_hold <= bus.iv_din;
      if (w_load)
        r_hold_full <= w_accept;
      else if (w_accept)
        r_hold_full <= 1'b1;
      if (i_en) begin
        r_dout_valid <= w_last;
        if (w_load) begin
          r_shift  <= r_hold[LENGTH-1:1];
          r_dout   <= r_hold[0];
          r_cnt    <= '0;
          r_active <= 1'b1;
        end else if (r_active && !w_last) begin
          r_shift <= r_shift >> 1;
          r_dout  <= r_shift[0];
          r_cnt   <= r_cnt + CW'(1);
        end else begin
          r_active <= 1'b0;
          r_dout   <= 1'b0;
          r_cnt    <= '0;
        end
      end
    end
  end

  assign bus.o_din_ready  = ~r_hold_full;
  assign bus.o_dout       = r_dout;
  assign bus.o_dout_valid = r_dout_valid;
  assign bus.o_busy       = r_active | r_hold_full;
endmodule

// File: tb/tb_serializer.sv
// Directed and randomized checks of the serializer against a
// receive-side model that reassembles words from the bit stream.
`timescale 1ns/1ps
module tb_serializer;
  localparam int L = 24;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic en2;

  always #5 clk = ~clk;

  serializer_if #(.LENGTH(L)) bus ();
  serializer_if #(.LENGTH(2)) bus2 ();

  serializer #(.LENGTH(L)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .bus   (bus)
  );

  serializer #(.LENGTH(2)) dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en2),
    .bus   (bus2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Isolated word with en=1: accept, L bits, strobe with idle line.
  task automatic send_one(input logic [L-1:0] w,
                          input string tag);
    bus.iv_din      = w;
    bus.i_din_valid = 1'b1;
    tick();
    bus.i_din_valid = 1'b0;
    chk({tag, "_rdy_drop"}, 32'(bus.o_din_ready), 0);
    chk({tag, "_acc_dout"}, 32'(bus.o_dout), 0);
    for (int i = 0; i < L; i++) begin
      tick();
      chk({tag, "_bit"}, 32'(bus.o_dout), 32'(w[i]));
      chk({tag, "_nostb"}, 32'(bus.o_dout_valid), 0);
    end
    tick();
    chk({tag, "_stb"}, 32'(bus.o_dout_valid), 1);
    chk({tag, "_stb_dout"}, 32'(bus.o_dout), 0);
    chk({tag, "_idle"}, 32'(bus.o_busy), 0);
    tick();
    chk({tag, "_stb_clr"}, 32'(bus.o_dout_valid), 0);
  endtask

  logic [L-1:0] words [3];
  logic [L-1:0] q [$];
  logic [L-1:0] rx;
  logic [L-1:0] wa;
  logic [L-1:0] din_s;
  logic [L-1:0] ew;
  logic [5:0]   ed2;
  logic [5:0]   ev2;
  logic         acc;
  logic         pd;
  logic         pv;
  logic         ren;
  logic         prev_dv;
  logic         exp_d;
  logic         exp_v;
  int           idx;
  int           sent;
  int           rcv;
  int           cyc;

  initial begin
    rst              = 1'b1;
    en               = 1'b0;
    en2              = 1'b0;
    bus.iv_din       = '0;
    bus.i_din_valid  = 1'b0;
    bus2.iv_din      = '0;
    bus2.i_din_valid = 1'b0;
    #12;
    chk("rst_dout", 32'(bus.o_dout), 0);
    chk("rst_dv", 32'(bus.o_dout_valid), 0);
    chk("rst_rdy", 32'(bus.o_din_ready), 1);
    chk("rst_busy", 32'(bus.o_busy), 0);
    tick();
    rst = 1'b0;
    en  = 1'b1;

    send_one(24'hA5F00F, "single");

    // Back-to-back stream; din scrambled while ready is low.
    words[0] = 24'h000001;
    words[1] = 24'h800000;
    words[2] = 24'hFFFFFF;
    idx = 0;
    for (int n = 0; n < 76; n++) begin
      if (idx < 3) begin
        bus.i_din_valid = 1'b1;
        bus.iv_din = bus.o_din_ready ? words[idx] : L'($urandom);
      end else begin
        bus.i_din_valid = 1'b0;
      end
      acc = bus.i_din_valid & bus.o_din_ready;
      tick();
      if (acc) idx++;
      if (n >= 1 && n <= 72) begin
        ew    = words[(n - 1) / L];
        exp_d = ew[(n - 1) % L];
      end else begin
        exp_d = 1'b0;
      end
      exp_v = (n == 25) || (n == 49) || (n == 73);
      chk("strm_dout", 32'(bus.o_dout), 32'(exp_d));
      chk("strm_dv", 32'(bus.o_dout_valid), 32'(exp_v));
    end
    chk("strm_all_acc", idx, 3);
    chk("strm_idle", 32'(bus.o_busy), 0);

    // Random traffic with a sparse enable, checked by reassembly.
    rx      = '0;
    sent    = 0;
    rcv     = 0;
    cyc     = 0;
    prev_dv = 1'b0;
    while (rcv < 100 && cyc < 40000) begin
      en = ($urandom_range(2) == 0);
      bus.i_din_valid = (sent < 100) && ($urandom_range(3) != 0);
      bus.iv_din = L'($urandom);
      din_s = bus.iv_din;
      acc = bus.i_din_valid & bus.o_din_ready;
      pd  = bus.o_dout;
      pv  = bus.o_dout_valid;
      ren = en;
      tick();
      cyc++;
      if (acc) begin
        q.push_back(din_s);
        sent++;
        chk("rnd_rdy_drop", 32'(bus.o_din_ready), 0);
      end
      if (!ren) begin
        chk("rnd_hold_dout", 32'(bus.o_dout), 32'(pd));
        chk("rnd_hold_dv", 32'(bus.o_dout_valid), 32'(pv));
      end else begin
        if (bus.o_dout_valid) begin
          chk("rnd_no_double", 32'(prev_dv), 0);
          if (q.size() == 0) begin
            chk("rnd_spurious", 1, 0);
          end else begin
            chk("rnd_word", 32'(rx), 32'(q.pop_front()));
          end
          rcv++;
        end
        prev_dv = bus.o_dout_valid;
        rx = {bus.o_dout, rx[L-1:1]};
      end
    end
    chk("rnd_count", rcv, 100);
    bus.i_din_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rnd_drained", 32'(bus.o_busy), 0);

    // Reset at bit 10 with a second word held.
    wa = 24'hDEAD01;
    bus.iv_din      = wa;
    bus.i_din_valid = 1'b1;
    tick();
    bus.iv_din = 24'hBEEF02;
    tick();
    tick();
    bus.i_din_valid = 1'b0;
    chk("mid_held", 32'(bus.o_din_ready), 0);
    for (int n = 3; n <= 11; n++) tick();
    chk("mid_bit10", 32'(bus.o_dout), 32'(wa[10]));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", 32'(bus.o_dout), 0);
    chk("mid_rst_dv", 32'(bus.o_dout_valid), 0);
    chk("mid_rst_rdy", 32'(bus.o_din_ready), 1);
    chk("mid_rst_busy", 32'(bus.o_busy), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("mid_quiet", {30'd0, bus.o_dout_valid, bus.o_busy}, 0);
    end
    send_one(24'h123456, "post_rst");

    // LENGTH=2 back-to-back.
    en2 = 1'b1;
    ed2 = 6'b000110;
    ev2 = 6'b010100;
    bus2.iv_din      = 2'b10;
    bus2.i_din_valid = 1'b1;
    tick();
    bus2.iv_din = 2'b01;
    for (int n = 1; n <= 6; n++) begin
      acc = bus2.i_din_valid & bus2.o_din_ready;
      tick();
      if (acc) bus2.i_din_valid = 1'b0;
      chk("l2_dout", 32'(bus2.o_dout), 32'(ed2[n-1]));
      chk("l2_dv", 32'(bus2.o_dout_valid), 32'(ev2[n-1]));
    end
    chk("l2_idle", 32'(bus2.o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
